// File: rtl/addsub_accum_unit.sv
// Sequential add/subtract/accumulate unit with valid/ready handshakes and carry/overflow/zero flags.
// A command is accepted in IDLE, computed in EXEC and held in DONE until the consumer takes it.
module addsub_accum_unit #(
    parameter int WIDTH    = 6,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] opx, opy, res_fin;
    logic             cin, ovf_raw, carry_fin;
    logic [WIDTH:0]   sum_raw;

    // Subtraction is A + ~B + 1, so bit WIDTH of the sum is the NOT-borrow.
    always_comb begin
        opx = '0;
        opy = '0;
        cin = 1'b0;
        case (sel_q)
            OP_ADD: begin opx = a_q;   opy = b_q;               end
            OP_SUB: begin opx = a_q;   opy = ~b_q; cin = 1'b1;  end
            OP_ACC: begin opx = acc_q; opy = a_q;               end
            default: ;
        endcase
        sum_raw   = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
        ovf_raw   = (opx[WIDTH-1] == opy[WIDTH-1]) && (sum_raw[WIDTH-1] != opx[WIDTH-1]);
        carry_fin = sum_raw[WIDTH];
        res_fin   = sum_raw[WIDTH-1:0];
        if (SATURATE) begin
            if (sel_q == OP_SUB && !carry_fin)
                res_fin = '0;
            else if (sel_q != OP_SUB && carry_fin)
                res_fin = '1;
        end
        if (sel_q == OP_CLR) begin
            res_fin   = '0;
            carry_fin = 1'b0;
            ovf_raw   = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = op_a;
                        b_d     = op_b;
                        sel_d   = op_sel;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    result_d    = res_fin;
                    carry_d     = carry_fin;
                    ovf_d       = ovf_raw;
                    zero_d      = (res_fin == '0);
                    out_valid_d = 1'b1;
                    if (sel_q == OP_ACC || sel_q == OP_CLR)
                        acc_d = res_fin;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= OP_ADD;
            acc_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_accum_unit.sv
// Directed bench for addsub_accum_unit: a wrapping instance and a saturating instance share stimulus.
module tb_addsub_accum_unit;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst, ena, in_valid, out_ready;
    logic [W-1:0] op_a, op_b;
    logic [1:0]   op_sel;

    logic         w_in_ready, w_out_valid, w_carry, w_ovf, w_zero;
    logic [W-1:0] w_result;
    logic         s_in_ready, s_out_valid, s_carry, s_ovf, s_zero;
    logic [W-1:0] s_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_accum_unit #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(w_in_ready),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .out_valid(w_out_valid),
        .out_ready(out_ready), .result(w_result), .carry(w_carry),
        .overflow(w_ovf), .zero(w_zero)
    );

    addsub_accum_unit #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(s_in_ready),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .out_valid(s_out_valid),
        .out_ready(out_ready), .result(s_result), .carry(s_carry),
        .overflow(s_ovf), .zero(s_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command with out_ready high and check both instances' results.
    task automatic run_op(input string tag, input logic [1:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] wr, input logic [W-1:0] sr,
                          input logic ec, input logic eo);
        op_sel = sel; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_vld_early"}, {31'd0, w_out_valid}, 32'd0);
        tick();
        chk({tag, "_vld"},    {31'd0, w_out_valid}, 32'd1);
        chk({tag, "_res"},    {26'd0, w_result}, {26'd0, wr});
        chk({tag, "_carry"},  {31'd0, w_carry}, {31'd0, ec});
        chk({tag, "_ovf"},    {31'd0, w_ovf}, {31'd0, eo});
        chk({tag, "_zero"},   {31'd0, w_zero}, {31'd0, (wr == '0)});
        chk({tag, "_sres"},   {26'd0, s_result}, {26'd0, sr});
        chk({tag, "_scarry"}, {31'd0, s_carry}, {31'd0, ec});
        chk({tag, "_szero"},  {31'd0, s_zero}, {31'd0, (sr == '0)});
        tick();
        chk({tag, "_rdy_back"}, {31'd0, w_in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sel = 2'b00;
        #12;
        chk("rst_in_ready", {31'd0, w_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, w_out_valid}, 32'd0);
        chk("rst_result", {26'd0, w_result}, 32'd0);
        chk("rst_zero", {31'd0, w_zero}, 32'd1);
        chk("rst_carry", {31'd0, w_carry}, 32'd0);
        chk("rst_ovf", {31'd0, w_ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 42 exceeds the signed 6-bit range, so overflow is set.
        run_op("add25_17", 2'b00, 6'd25, 6'd17, 6'd42, 6'd42, 1'b0, 1'b1);
        run_op("add40_30", 2'b00, 6'd40, 6'd30, 6'd6,  6'd63, 1'b1, 1'b0);
        run_op("add31_1",  2'b00, 6'd31, 6'd1,  6'd32, 6'd32, 1'b0, 1'b1);
        run_op("sub5_9",   2'b01, 6'd5,  6'd9,  6'd60, 6'd0,  1'b0, 1'b0);
        run_op("sub9_9",   2'b01, 6'd9,  6'd9,  6'd0,  6'd0,  1'b1, 1'b0);
        run_op("acc20a",   2'b10, 6'd20, 6'd0,  6'd20, 6'd20, 1'b0, 1'b0);
        run_op("acc20b",   2'b10, 6'd20, 6'd55, 6'd40, 6'd40, 1'b0, 1'b1);
        run_op("acc30",    2'b10, 6'd30, 6'd0,  6'd6,  6'd63, 1'b1, 1'b0);
        run_op("clear",    2'b11, 6'd17, 6'd3,  6'd0,  6'd0,  1'b0, 1'b0);
        run_op("acc7",     2'b10, 6'd7,  6'd0,  6'd7,  6'd7,  1'b0, 1'b0);

        // Backpressure: the result must hold while a second command waits.
        op_sel = 2'b00; op_a = 6'd3; op_b = 6'd4; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        op_a = 6'd10; op_b = 6'd11;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", {31'd0, w_out_valid}, 32'd1);
            chk("bp_res", {26'd0, w_result}, 32'd7);
            chk("bp_rdy", {31'd0, w_in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_release_rdy", {31'd0, w_in_ready}, 32'd1);
        chk("bp_release_vld", {31'd0, w_out_valid}, 32'd0);
        tick();
        chk("bp_no_capture", {31'd0, w_out_valid}, 32'd0);

        // Enable low while in EXEC stalls the unit.
        op_sel = 2'b00; op_a = 6'd12; op_b = 6'd13; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ena_stall_vld", {31'd0, w_out_valid}, 32'd0);
            chk("ena_stall_rdy", {31'd0, w_in_ready}, 32'd0);
        end
        ena = 1'b1; out_ready = 1'b0;
        tick();
        chk("ena_done_vld", {31'd0, w_out_valid}, 32'd1);
        chk("ena_done_res", {26'd0, w_result}, 32'd25);

        // Reset pulse while in DONE, then the accumulator must restart from zero.
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_mid_vld", {31'd0, w_out_valid}, 32'd0);
        chk("rst_mid_res", {26'd0, w_result}, 32'd0);
        chk("rst_mid_zero", {31'd0, w_zero}, 32'd1);
        chk("rst_mid_rdy", {31'd0, w_in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op("acc5_after_rst", 2'b10, 6'd5, 6'd0, 6'd5, 6'd5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
